// File: rtl/iq_alloc_ctrl.sv
// Allocation controller for the collapsing issue queue: grants dispatch lanes, assigns slots, tracks occupancy.
// Build macro IQ_ALLOC_STATS_EN adds the stall_cnt / peak_cnt statistics outputs.
module iq_alloc_ctrl #(
  parameter int DEPTH   = 16,
  parameter int ALLOC_W = 2,
  parameter int REL_W   = 4,
  parameter int RET_W   = 4,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [REL_W-1:0]      rel,
  input  logic [RET_W-1:0]      ret,
  input  logic [ALLOC_W-1:0]    alloc_vld,
  output logic [ALLOC_W-1:0]    alloc_gnt,
  output logic [ALLOC_W*AW-1:0] alloc_addr,
  output logic [AW:0]           count,
  output logic                  full,
  output logic                  empty,
  output logic                  err
`ifdef IQ_ALLOC_STATS_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [AW:0]           peak_cnt
`endif
);

  localparam logic signed [AW+1:0] DEPTH_S = (AW+2)'(DEPTH);

  function automatic logic [AW:0] popcnt(input logic [31:0] v);
    logic [AW:0] n;
    n = {(AW+1){1'b0}};
    for (int k = 0; k < 32; k++) begin
      n = n + {{AW{1'b0}}, v[k]};
    end
    return n;
  endfunction

  logic [AW:0]          count_r;
  logic                 full_r;
  logic                 empty_r;
  logic                 err_r;
  logic signed [AW+1:0] cnt_s;
  logic signed [AW+1:0] rel_sum_s;
  logic signed [AW+1:0] ret_sum_s;
  logic signed [AW+1:0] free_s;
  logic signed [AW+1:0] base_s;
  logic signed [AW+1:0] next_s;
  logic signed [AW+1:0] idx_s;
  logic                 ovf_s;
  logic                 unf_s;
  logic                 chain_s;
  logic                 err_nxt_s;
  logic [ALLOC_W-1:0]   gnt_s;
  logic [ALLOC_W*AW-1:0] addr_s;

  // Free space, collapse base, in-order lane grants and next occupancy.
  always_comb begin
    cnt_s     = signed'({1'b0, count_r});
    rel_sum_s = signed'({1'b0, popcnt(32'(rel))});
    ret_sum_s = signed'({1'b0, popcnt(32'(ret))});
    free_s    = DEPTH_S - cnt_s - ret_sum_s;
    base_s    = cnt_s - rel_sum_s + ret_sum_s;
    ovf_s     = ret_sum_s > (DEPTH_S - cnt_s);
    unf_s     = rel_sum_s > (cnt_s + ret_sum_s);
    gnt_s     = {ALLOC_W{1'b0}};
    addr_s    = {(ALLOC_W*AW){1'b1}};
    chain_s   = 1'b1;
    idx_s     = {(AW+2){1'b0}};
    for (int i = 0; i < ALLOC_W; i++) begin
      idx_s = (AW+2)'(i);
      // A refused lane breaks the chain so dispatch stays strictly in order.
      if (chain_s && alloc_vld[i] && (idx_s < free_s) && !flush && !ovf_s) begin
        gnt_s[i]              = 1'b1;
        addr_s[i*AW +: AW]    = base_s[AW-1:0] + AW'(i);
      end else begin
        chain_s = 1'b0;
      end
    end
    if (flush) begin
      next_s = {(AW+2){1'b0}};
    end else if (ovf_s) begin
      next_s = DEPTH_S;
    end else if (unf_s) begin
      next_s = {(AW+2){1'b0}};
    end else begin
      next_s = base_s + signed'({1'b0, popcnt(32'(gnt_s))});
    end
    err_nxt_s = err_r | (!flush & (ovf_s | unf_s));
  end

  // Occupancy, status flags and sticky error register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {(AW+1){1'b0}};
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      err_r   <= 1'b0;
    end else begin
      count_r <= next_s[AW:0];
      full_r  <= (next_s == DEPTH_S);
      empty_r <= (next_s == {(AW+2){1'b0}});
      err_r   <= err_nxt_s;
    end
  end

  assign alloc_gnt  = gnt_s;
  assign alloc_addr = addr_s;
  assign count      = count_r;
  assign full       = full_r;
  assign empty      = empty_r;
  assign err        = err_r;

`ifdef IQ_ALLOC_STATS_EN
  logic [31:0] stall_r;
  logic [AW:0] peak_r;
  logic        stall_s;

  assign stall_s = |(alloc_vld & ~gnt_s);

  // Saturating stall counter and high-water mark; flush leaves both alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_r <= 32'd0;
      peak_r  <= {(AW+1){1'b0}};
    end else begin
      if (stall_s && (stall_r != 32'hFFFF_FFFF)) begin
        stall_r <= stall_r + 32'd1;
      end else begin
        stall_r <= stall_r;
      end
      if (next_s[AW:0] > peak_r) begin
        peak_r <= next_s[AW:0];
      end else begin
        peak_r <= peak_r;
      end
    end
  end

  assign stall_cnt = stall_r;
  assign peak_cnt  = peak_r;
`endif

endmodule

// File: tb/tb_iq_alloc_ctrl.sv
// Self-checking bench for iq_alloc_ctrl: vector table, directed corner sequences and randomized model check.
module tb_iq_alloc_ctrl;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] rel = 4'd0;
  logic [3:0] ret = 4'd0;
  logic [1:0] alloc_vld = 2'd0;
  logic [1:0] alloc_gnt;
  logic [7:0] alloc_addr;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       err;
`ifdef IQ_ALLOC_STATS_EN
  logic [31:0] stall_cnt;
  logic [4:0]  peak_cnt;
`endif

  iq_alloc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .rel(rel), .ret(ret),
    .alloc_vld(alloc_vld), .alloc_gnt(alloc_gnt), .alloc_addr(alloc_addr),
    .count(count), .full(full), .empty(empty), .err(err)
`ifdef IQ_ALLOC_STATS_EN
    , .stall_cnt(stall_cnt), .peak_cnt(peak_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mcount = 0;
  bit merr = 1'b0;

  typedef struct {
    logic       fl;
    logic [3:0] rl;
    logic [3:0] rt;
    logic [1:0] v;
    logic [1:0] gnt;
    int         a0;
    int         a1;
    int         cnt;
    bit         e;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", nm, act, exp);
    end
  endtask

  // Queue occupancy rules expressed as plain integer arithmetic.
  task automatic model(input logic fl, input logic [3:0] rl, input logic [3:0] rt, input logic [1:0] v,
                       output logic [1:0] g, output logic [7:0] a, output int nxt, output bit bad);
    int r, t, fr, b, ng;
    bit ok;
    r = $countones(rl);
    t = $countones(rt);
    g = 2'b00;
    a = 8'hFF;
    bad = 1'b0;
    ng = 0;
    if (fl) begin
      nxt = 0;
    end else begin
      fr = DEPTH - mcount - t;
      b  = mcount - r + t;
      ok = 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (ok && v[i] && (i < fr)) begin
          g[i] = 1'b1;
          a[i*4 +: 4] = 4'((b + i) & 15);
          ng++;
        end else begin
          ok = 1'b0;
        end
      end
      if (t > DEPTH - mcount) begin
        nxt = DEPTH; bad = 1'b1; g = 2'b00; a = 8'hFF;
      end else if (r > mcount + t) begin
        nxt = 0; bad = 1'b1;
      end else begin
        nxt = b + ng;
      end
    end
  endtask

  task automatic cyc(input logic fl, input logic [3:0] rl, input logic [3:0] rt, input logic [1:0] v,
                     output logic [1:0] ag, output logic [7:0] aa, output int ac, output logic ae);
    logic [1:0] g;
    logic [7:0] a;
    int nxt;
    bit bad;
    @(negedge clk);
    flush = fl; rel = rl; ret = rt; alloc_vld = v;
    #1;
    model(fl, rl, rt, v, g, a, nxt, bad);
    ag = alloc_gnt;
    aa = alloc_addr;
    chk("gnt", 32'(alloc_gnt), 32'(g));
    chk("addr", 32'(alloc_addr), 32'(a));
    @(posedge clk);
    #1;
    mcount = nxt;
    merr = merr | bad;
    ac = int'(count);
    ae = err;
    chk("count", 32'(count), 32'(mcount));
    chk("full", 32'(full), 32'(mcount == DEPTH));
    chk("empty", 32'(empty), 32'(mcount == 0));
    chk("err", 32'(err), 32'(merr));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; flush = 1'b0; rel = 4'd0; ret = 4'd0; alloc_vld = 2'd0;
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_gnt", 32'(alloc_gnt), 32'd0);
    chk("rst_addr", 32'(alloc_addr), 32'hFF);
    mcount = 0;
    merr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [1:0] ag;
  logic [7:0] aa;
  int         ac;
  logic       ae;

  initial begin
    tbl[0] = '{1'b0, 4'b0000, 4'b0000, 2'b10, 2'b00, 15, 15, 0, 1'b0};
    tbl[1] = '{1'b0, 4'b0000, 4'b0000, 2'b01, 2'b01,  0, 15, 1, 1'b0};
    tbl[2] = '{1'b0, 4'b0000, 4'b0000, 2'b11, 2'b11,  1,  2, 3, 1'b0};
    tbl[3] = '{1'b0, 4'b0001, 4'b0000, 2'b11, 2'b11,  2,  3, 4, 1'b0};
    tbl[4] = '{1'b0, 4'b0000, 4'b0111, 2'b11, 2'b11,  7,  8, 9, 1'b0};
    tbl[5] = '{1'b1, 4'b1111, 4'b0000, 2'b11, 2'b00, 15, 15, 0, 1'b0};

    do_reset();
    for (int n = 0; n < 6; n++) begin
      cyc(tbl[n].fl, tbl[n].rl, tbl[n].rt, tbl[n].v, ag, aa, ac, ae);
      chk("tbl_gnt", 32'(ag), 32'(tbl[n].gnt));
      chk("tbl_addr0", 32'(aa[3:0]), 32'(tbl[n].a0));
      chk("tbl_addr1", 32'(aa[7:4]), 32'(tbl[n].a1));
      chk("tbl_count", 32'(ac), 32'(tbl[n].cnt));
      chk("tbl_err", 32'(ae), 32'(tbl[n].e));
    end

    // Fill from empty two slots per cycle, then three blocked cycles at full.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 4'd0, 4'd0, 2'b11, ag, aa, ac, ae);
      chk("fill_addr0", 32'(aa[3:0]), 32'(2 * k));
      chk("fill_addr1", 32'(aa[7:4]), 32'(2 * k + 1));
    end
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 4'd0, 4'd0, 2'b11, ag, aa, ac, ae);
      chk("full_gnt", 32'(ag), 32'd0);
      chk("full_count", 32'(ac), 32'd16);
      chk("full_flag", 32'(full), 32'd1);
    end
`ifdef IQ_ALLOC_STATS_EN
    chk("stall_cnt", stall_cnt, 32'd3);
    chk("peak_cnt", 32'(peak_cnt), 32'd16);
`endif

    // One free slot left: only lane 0 fits.
    cyc(1'b0, 4'b0001, 4'd0, 2'b00, ag, aa, ac, ae);
    cyc(1'b0, 4'd0, 4'd0, 2'b11, ag, aa, ac, ae);
    chk("last_gnt", 32'(ag), 32'b01);
    chk("last_addr0", 32'(aa[3:0]), 32'd15);
    chk("last_addr1", 32'(aa[7:4]), 32'd15);
    chk("last_count", 32'(ac), 32'd16);

    // Same-cycle release and return move the collapse base.
    cyc(1'b0, 4'b1111, 4'd0, 2'b00, ag, aa, ac, ae);
    cyc(1'b0, 4'b0011, 4'd0, 2'b00, ag, aa, ac, ae);
    chk("pre_count", 32'(ac), 32'd10);
    cyc(1'b0, 4'b0111, 4'b0001, 2'b11, ag, aa, ac, ae);
    chk("mix_gnt", 32'(ag), 32'b11);
    chk("mix_addr0", 32'(aa[3:0]), 32'd8);
    chk("mix_addr1", 32'(aa[7:4]), 32'd9);
    chk("mix_count", 32'(ac), 32'd10);

    // Underflow sets sticky err that flush cannot clear.
    cyc(1'b1, 4'd0, 4'd0, 2'b00, ag, aa, ac, ae);
    cyc(1'b0, 4'd0, 4'd0, 2'b11, ag, aa, ac, ae);
    cyc(1'b0, 4'b1111, 4'd0, 2'b00, ag, aa, ac, ae);
    chk("unf_count", 32'(ac), 32'd0);
    chk("unf_err", 32'(ae), 32'd1);
    cyc(1'b1, 4'd0, 4'd0, 2'b00, ag, aa, ac, ae);
    chk("flush_err", 32'(ae), 32'd1);
    do_reset();

    // Return into a full queue overflows and blocks grants.
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 4'd0, 4'd0, 2'b11, ag, aa, ac, ae);
    end
    cyc(1'b0, 4'd0, 4'b0001, 2'b11, ag, aa, ac, ae);
    chk("ovf_gnt", 32'(ag), 32'd0);
    chk("ovf_count", 32'(ac), 32'd16);
    chk("ovf_err", 32'(ae), 32'd1);
    do_reset();

    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 15) == 0), 4'($urandom & $urandom), 4'($urandom & $urandom & $urandom),
          2'($urandom), ag, aa, ac, ae);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/iq_alloc_ctrl.md
# iq_alloc_ctrl

Parametrised allocation controller for the collapsing instruction issue queue. Each cycle it takes up to ALLOC_W in-order dispatch requests, REL_W per-slot release strobes (entries issued out) and RET_W return strobes (entries replayed back), grants as many dispatch lanes as space allows, and drives each granted lane's post-collapse slot address. It keeps the registered occupancy count, which doubles as the queue write pointer, plus full/empty/error status. It sits between the dispatch stage and the queue entry array.

## Interface
- DEPTH, 16, number of queue entries (power of two, ≥4)
- ALLOC_W, 2, dispatch lanes per cycle (1..4)
- REL_W, 4, release strobes per cycle
- RET_W, 4, return strobes per cycle
- AW, $clog2(DEPTH), slot address width (derived, not overridden)

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of occupancy
- rel  in  REL_W  release strobes; any bit pattern allowed
- ret  in  RET_W  return strobes; any bit pattern allowed
- alloc_vld  in  ALLOC_W  dispatch request per lane
- alloc_gnt  out  ALLOC_W  lane granted this cycle
- alloc_addr  out  ALLOC_W*AW  slot per lane, lane i at bits [i*AW +: AW]
- count  out  AW+1  registered occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- err  out  1  sticky under/overflow flag

## Operation
- rel_sum = popcount(rel), ret_sum = popcount(ret), both AW+1 bits wide; all arithmetic in AW+2 bits, signed internally.
- free = DEPTH − count − ret_sum. Returns have priority over dispatch. Same-cycle releases are not credited (conservative).
- Lanes grant in order: alloc_gnt[i] = alloc_vld[i] & alloc_gnt[i−1] & (i < free) & ~flush. Lane 0 ignores the prior-lane term. A gap in alloc_vld blocks every higher lane.
- base = count − rel_sum + ret_sum. alloc_addr[i] = base + i, truncated to AW bits, for each granted lane. Ungranted lanes drive all-ones.
- next = base + popcount(alloc_gnt).
- Underflow: if rel_sum > count + ret_sum, next saturates at 0 and err sets.
- Overflow: if ret_sum > DEPTH − count, next saturates at DEPTH, err sets, and no lane is granted.
- flush: next = 0 and there are no grants; rel/ret are ignored that cycle. err is not cleared by flush.
- err clears only on reset.

## Timing
- Reset (async assert, sync release) sets count=0, err=0. Outputs then read full=0, empty=1, alloc_gnt=0, and all alloc_addr all-ones.
- alloc_gnt and alloc_addr are combinational from inputs and registered count, with zero-cycle latency. The queue array writes the granted slots on the same edge that count updates.
- count, full, empty and err reflect the cycle's effects one cycle later.
- Reset mid-cycle discards that cycle's grants; the dispatch stage must treat them as not taken.
- Critical path: popcounts → subtract → ALLOC_W adders. No internal pipelining.

## Configuration
- IQ_ALLOC_STATS_EN defined: adds outputs stall_cnt (32 bits) and peak_cnt (AW+1 bits).
  - stall_cnt increments, saturating, on every cycle with any alloc_vld bit set and that bit not granted.
  - peak_cnt holds the maximum count seen since reset.
  - Both reset to 0 and are unaffected by flush.
- IQ_ALLOC_STATS_EN undefined: these ports and their registers do not exist. Behaviour is otherwise identical.

## Test plan
- Defaults, reset, alloc_vld=2'b11 for 8 cycles with no rel/ret → addresses (0,1),(2,3)…(14,15), then count=16, full=1, gnt=00 on the 9th cycle.
- count=15, alloc_vld=11 → gnt=01, addr0=15, addr1=15 (all-ones), count→16.
- count=10, rel=4'b0111, ret=4'b0001, alloc_vld=11 → base=8, addrs 8,9, count→10.
- count=2, rel=4'b1111 → count→0, err=1 and stays 1 after flush; only rst_n low clears it.
- alloc_vld=10 at count=0 → gnt=00 (lane gap). A flush with alloc_vld=11 at count=9 → gnt=00, count→0.
- With IQ_ALLOC_STATS_EN: 3 blocked cycles at full → stall_cnt=3, peak_cnt=16.
